// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A start/busy/done handshake wraps a single full-subtractor cell and one borrow flip-flop.
module serial_subtractor_nbit #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out,
    output logic                 zero
);

    localparam int CNT_W = $clog2(BIT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [BIT_WIDTH-1:0] sa;
    logic [BIT_WIDTH-1:0] sb;
    logic [BIT_WIDTH-1:0] sr;
    logic                 br;
    logic [CNT_W-1:0]     cnt;

    logic                 accept;
    logic                 last_bit;
    logic                 d;
    logic                 br_next;
    logic [BIT_WIDTH-1:0] sr_next;

    // Full-subtractor cell plus the control decodes shared by the FSM and datapath
    always_comb begin
        accept   = start && ((state == IDLE) || (state == DONE));
        last_bit = (state == SHIFT) && (cnt == CNT_W'(BIT_WIDTH - 1));
        d        = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sr_next  = {d, sr[BIT_WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand/result shifters; published outputs move only on the completing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b1;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            br  <= borrow_in;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_next;
            br  <= br_next;
            cnt <= cnt + CNT_W'(1);
            if (last_bit) begin
                diff       <= sr_next;
                borrow_out <= br_next;
                zero       <= (sr_next == '0);
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

`ifndef SYNTHESIS
    logic [BIT_WIDTH-1:0] cap_a;
    logic [BIT_WIDTH-1:0] cap_b;
    logic                 cap_bin;
    logic [BIT_WIDTH:0]   cap_expect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_bin <= 1'b0;
        end else if (accept) begin
            cap_a   <= a;
            cap_b   <= b;
            cap_bin <= borrow_in;
        end
    end

    assign cap_expect = {1'b0, cap_a} - {1'b0, cap_b} - {{BIT_WIDTH{1'b0}}, cap_bin};

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            assert (!$isunknown({a, b, borrow_in}))
                else $error("serial_subtractor_nbit: unknown operand bits at start");
        end
        if (!rst && last_bit) begin
            assert ({br_next, sr_next} == cap_expect)
                else $error("serial_subtractor_nbit: result %0h differs from %0h",
                            {br_next, sr_next}, cap_expect);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit: directed vectors, an arithmetic
// reference model compared every cycle, and randomised operations.
module tb_serial_subtractor_nbit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;

    int n_checks = 0;
    int n_pass = 0;
    bit checking = 1'b0;

    serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .borrow_in(borrow_in),
        .busy(busy),
        .done(done),
        .diff(diff),
        .borrow_out(borrow_out),
        .zero(zero)
    );

    always #5 clk = ~clk;

    // Reference model: a countdown of remaining bit-cycles and the full-width difference
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    bit           m_bo = 1'b0;
    bit           m_zero = 1'b1;
    logic [W:0]   m_pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_bo   = 1'b0;
            m_zero = 1'b1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_diff = m_pend[W-1:0];
                m_bo   = m_pend[W];
                m_zero = (m_pend[W-1:0] == '0);
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_pend = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
                m_left = W;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking && !rst) begin
            checkOutput("cycle {busy,done,bo,zero,diff}",
                        {20'd0, busy, done, borrow_out, zero, diff},
                        {20'd0, (m_left > 0), m_done, m_bo, m_zero, m_diff});
        end
    end

    // Presents one operation for a single accepting edge; returns at the negedge after it
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vbin);
        @(negedge clk);
        a         = va;
        b         = vb;
        borrow_in = vbin;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            $display("[TB] FAIL done timeout: got done=%b, expected 1", done);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int gap;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic [W:0]   rexp;

        #3 rst = 1'b1;
        #1 checkOutput("reset outputs", {20'd0, busy, done, borrow_out, zero, diff}, 32'h100);
        checking = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h35, 8'h12, 1'b0);
        wait_done(lat);
        checkOutput("latency 35-12", lat, 8);
        checkOutput("diff 35-12", diff, 8'h23);
        checkOutput("bo 35-12", borrow_out, 0);
        checkOutput("zero 35-12", zero, 0);

        applyStimulus(8'h00, 8'h01, 1'b0);
        wait_done(lat);
        checkOutput("diff 00-01", diff, 8'hFF);
        checkOutput("bo 00-01", borrow_out, 1);

        applyStimulus(8'h80, 8'h80, 1'b1);
        wait_done(lat);
        checkOutput("diff 80-80-1", diff, 8'hFF);
        checkOutput("bo 80-80-1", borrow_out, 1);

        applyStimulus(8'h5A, 8'h5A, 1'b0);
        wait_done(lat);
        checkOutput("diff 5A-5A", diff, 8'h00);
        checkOutput("zero 5A-5A", zero, 1);
        checkOutput("bo 5A-5A", borrow_out, 0);
        repeat (3) @(negedge clk);
        checkOutput("diff held idle", diff, 8'h00);

        applyStimulus(8'hF0, 8'h0F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'h00;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("diff held while busy", diff, 8'h00);
        wait_done(lat);
        checkOutput("diff F0-0F ignored start", diff, 8'hE1);
        checkOutput("bo F0-0F", borrow_out, 0);
        @(negedge clk);
        checkOutput("single done pulse", done, 0);

        @(negedge clk);
        a         = 8'h10;
        b         = 8'h01;
        borrow_in = 1'b0;
        start     = 1'b1;
        wait_done(lat);
        checkOutput("b2b first diff", diff, 8'h0F);
        checkOutput("b2b first bo", borrow_out, 0);
        a = 8'h01;
        b = 8'h02;
        @(negedge clk);
        wait_done(gap);
        start = 1'b0;
        checkOutput("b2b done spacing", gap + 1, 9);
        checkOutput("b2b second diff", diff, 8'hFF);
        checkOutput("b2b second bo", borrow_out, 1);

        applyStimulus(8'h35, 8'h12, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 checkOutput("abort {busy,done,diff}", {22'd0, busy, done, diff}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(1, 0));
            rexp = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            applyStimulus(ra, rb, rbin);
            wait_done(lat);
            checkOutput("random {bo,diff}", {23'd0, borrow_out, diff}, {23'd0, rexp});
        end

        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_nbit

Bit-serial, multi-cycle N-bit subtractor computing `diff = a - b - borrow_in` one bit per clock, LSB first, with a single borrow flip-flop. It is the subtract-side counterpart of the ripple-carry adder datapath. It trades BIT_WIDTH cycles of latency for one full-subtractor cell. A start/busy/done handshake lets a controller FSM issue operations and collect results.

## Interface

- `BIT_WIDTH`, default 8: operand and result width; legal range 2..32.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation; sampled only in IDLE or DONE.
- `a` input BIT_WIDTH: minuend; captured on the accepting edge.
- `b` input BIT_WIDTH: subtrahend; captured on the accepting edge.
- `borrow_in` input 1: borrow into bit 0; captured on the accepting edge.
- `busy` output 1: high while bits are being processed.
- `done` output 1: one-cycle pulse when the result registers update.
- `diff` output BIT_WIDTH: registered result, held until the next completion.
- `borrow_out` output 1: registered borrow out of the MSB (unsigned underflow).
- `zero` output 1: registered, high when the completed `diff == 0`.

## Operation

- FSM states:
  - IDLE: waiting for `start`.
  - SHIFT: processing bits.
  - DONE: result published.
- IDLE with `start`=1 at an edge:
  - Load `a` and `b` into shift registers `sa` and `sb`.
  - Load `borrow_in` into the borrow flip-flop `br`.
  - Clear bit counter `cnt` to 0.
  - Go to SHIFT.
- SHIFT, each edge:
  - `d = sa[0] ^ sb[0] ^ br`.
  - `br <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`.
  - Shift `sa` and `sb` right by 1.
  - Shift `d` into the MSB of internal result register `sr`.
  - `cnt <= cnt + 1`.
- When `cnt == BIT_WIDTH-1` in SHIFT, the same edge also:
  - Writes the final `sr` value (including this `d`) to `diff`.
  - Writes the updated borrow to `borrow_out`.
  - Writes `zero`.
  - Goes to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1 is accepted exactly as in IDLE and goes to SHIFT, giving back-to-back operations.
  - Otherwise go to IDLE.
- `start` in SHIFT is ignored: no queuing and no effect on the in-flight operation.
- `cnt` width is $clog2(BIT_WIDTH)+1; it never wraps within an operation.
- `diff`, `borrow_out` and `zero` change only on the completing edge. They are stable while `busy`=1 and equal the previous result.
- Arithmetic is modulo 2^BIT_WIDTH. `borrow_out`=1 iff `a < b + borrow_in` (unsigned).
- Simulation checks (non-synthesizable, in the style of the adder's checks):
  - On the accepting edge, `$error` if any bit of `a`, `b` or `borrow_in` is not 0/1.
  - On completion, `$error` if `{borrow_out, diff}` ≠ `(a - b - borrow_in)` as captured.

## Timing

- Reset (async assert, sync release): state=IDLE, `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `zero`=1; `sa`, `sb`, `sr`, `br` and `cnt` cleared.
- `rst` mid-operation aborts immediately. No `done` is produced, and the previous result is lost (outputs take their reset values).
- Accepting edge E0: `busy` is high from after E0.
- SHIFT occupies edges E1..E_BIT_WIDTH. The completing edge is E_BIT_WIDTH.
- After the completing edge: `busy`=0, `done`=1, new `diff` visible.
- Latency from the accepting edge to `done` is BIT_WIDTH cycles. Throughput is one operation per BIT_WIDTH+1 cycles if `start` is held or re-asserted in DONE.
- `busy` = (state==SHIFT). `done` = (state==DONE). Both are decoded from registered state; there are no combinational paths from inputs to outputs.
- Inputs need to be valid only at the accepting edge.

## Test plan

All scenarios use BIT_WIDTH=8.

- Reset check: assert `rst` asynchronously mid-cycle → all outputs at reset values immediately (`zero`=1, others 0). Release, then `a`=0x35, `b`=0x12, `borrow_in`=0, pulse `start` → `done` exactly 8 cycles after the accepting edge; `diff`=0x23, `borrow_out`=0, `zero`=0.
- Underflow: `a`=0x00, `b`=0x01, `borrow_in`=0 → `diff`=0xFF, `borrow_out`=1. Then `a`=0x80, `b`=0x80, `borrow_in`=1 → `diff`=0xFF, `borrow_out`=1.
- Zero flag: `a`=0x5A, `b`=0x5A, `borrow_in`=0 → `diff`=0x00, `zero`=1, `borrow_out`=0. `diff` stays 0x00 through following idle cycles.
- Ignored start: start 0xF0−0x0F. In the 3rd busy cycle, drive `start`=1 with `a`=0x00, `b`=0xFF → result still 0xE1, `borrow_out`=0. Only one `done` pulse, and `diff` is unchanged while `busy`=1.
- Back-to-back and abort:
  - Hold `start`=1 with operands 0x10−0x01, then 0x01−0x02 presented in the DONE cycle → two `done` pulses 9 cycles apart; 0x0F/0, then 0xFF/1.
  - Assert `rst` on the 4th busy cycle → `busy`=0 at once, no `done`, `diff`=0x00.
- Random: 1000 random `a`, `b`, `borrow_in` operations checked against the reference model `{borrow_out, diff} = a - b - borrow_in` (9-bit), with no `$error` from the X-checks.
